// File: rtl/pow2_mac_array_pkg.sv
// Shared helpers for the power-of-two MAC array: product width,
// lane slice offsets and accumulator saturation bounds.
// Pure elaboration-time functions; no logic is generated here.
package pow2_mac_array_pkg;

  // Signed product width: activation plus the largest possible left shift.
  function automatic int prod_width(input int in_w, input int w_w);
    return in_w + (2 ** w_w) / 2;
  endfunction

  // LSB position of lane 'lane' inside a packed vector of w-bit lanes.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Largest value representable in an acc_w-bit signed accumulator.
  function automatic logic signed [63:0] acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in an acc_w-bit signed accumulator.
  function automatic logic signed [63:0] acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/pow2_mac_array_lane.sv
// One MAC lane: sign+shift product, stage-1 product register and a
// saturating accumulator with its own result register.
// Shared advance/clear control comes from the top; the lane holds when idle.
module pow2_mac_lane
  import pow2_mac_array_pkg::*;
#(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int ACC_BIT_WIDTH    = 24,
  parameter bit NEG_ZERO_IS_ZERO = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUT_BIT_WIDTH-1:0]  act_i,
  input  logic [WEIGHT_BIT_WIDTH-1:0] weight_i,
  input  logic                        load_i,     // accepted beat: capture product
  input  logic                        advance_i,  // stage-1 product moves into the accumulator
  input  logic                        first_i,    // ignore the old accumulator value
  input  logic                        emit_i,     // this product closes the sequence
  output logic [ACC_BIT_WIDTH-1:0]    out_o
);

  localparam int ProdW = prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH);
  localparam int ShW   = WEIGHT_BIT_WIDTH - 1;
  localparam int SumW  = ACC_BIT_WIDTH + 1;
  localparam logic signed [SumW-1:0] SumMax = SumW'(acc_max(ACC_BIT_WIDTH));
  localparam logic signed [SumW-1:0] SumMin = SumW'(acc_min(ACC_BIT_WIDTH));

  logic                            sign_w;
  logic [ShW-1:0]                  shamt;
  logic signed [ProdW-1:0]         act_ext;
  logic signed [ProdW-1:0]         base;
  logic signed [ProdW-1:0]         prod_d;
  logic signed [ProdW-1:0]         prod_q;
  logic signed [SumW-1:0]          acc_base;
  logic signed [SumW-1:0]          sum;
  logic signed [ACC_BIT_WIDTH-1:0] sat_d;
  logic signed [ACC_BIT_WIDTH-1:0] acc_q;
  logic [ACC_BIT_WIDTH-1:0]        out_q;

  // Product: activation zero-extended, optionally negated, then shifted.
  always_comb begin
    sign_w  = weight_i[WEIGHT_BIT_WIDTH-1];
    shamt   = weight_i[ShW-1:0];
    act_ext = ProdW'(act_i);
    base    = sign_w ? -act_ext : act_ext;
    prod_d  = base <<< shamt;
    if (NEG_ZERO_IS_ZERO && sign_w && (shamt == '0)) begin
      prod_d = '0;
    end
  end

  // Stage 1: product register, loaded only on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
    end else if (load_i) begin
      prod_q <= prod_d;
    end
  end

  // Sum one bit wider than the accumulator so overflow is visible, then clamp.
  always_comb begin
    acc_base = first_i ? '0 : SumW'(acc_q);
    sum      = acc_base + SumW'(prod_q);
    if (sum > SumMax) begin
      sat_d = SumMax[ACC_BIT_WIDTH-1:0];
    end else if (sum < SumMin) begin
      sat_d = SumMin[ACC_BIT_WIDTH-1:0];
    end else begin
      sat_d = sum[ACC_BIT_WIDTH-1:0];
    end
  end

  // Stage 2: accumulator and result register; result held until replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else if (advance_i) begin
      acc_q <= sat_d;
      if (emit_i) begin
        out_q <= sat_d;
      end
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pow2_mac_array.sv
// NUM_PE-lane power-of-two MAC array with saturating per-lane accumulators.
// Latency: last beat accepted -> result valid two edges later; 1 beat/cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes both stages.
module pow2_mac_array
  import pow2_mac_array_pkg::*;
#(
  parameter int NUM_PE           = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int ACC_BIT_WIDTH    = 24,
  parameter bit NEG_ZERO_IS_ZERO = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_PE*INPUT_BIT_WIDTH-1:0]  in_data,
  input  logic [NUM_PE*WEIGHT_BIT_WIDTH-1:0] in_weight,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_PE*ACC_BIT_WIDTH-1:0]    out_data
);

  localparam int ProductBitWidth = prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH);

  // The largest product magnitude always fits ProductBitWidth signed bits, so
  // an accumulator at least that wide can hold any single product unclamped.
  if (ACC_BIT_WIDTH < ProductBitWidth) begin : g_acc_width_check
    $error("pow2_mac_array: ACC_BIT_WIDTH too small for the product width");
  end

  logic stall;
  logic accept;
  logic advance;
  logic p_valid_q, p_valid_d;
  logic p_last_q,  p_last_d;
  logic first_q,   first_d;
  logic out_valid_q, out_valid_d;

  // Handshake and next-state for the shared pipeline control.
  always_comb begin
    stall   = out_valid_q && !out_ready;
    accept  = in_valid && !stall;
    advance = p_valid_q && !stall;

    p_valid_d = p_valid_q;
    p_last_d  = p_last_q;
    if (!stall) begin
      p_valid_d = accept;
      if (accept) begin
        p_last_d = in_last;
      end
    end

    first_d = first_q;
    if (advance) begin
      first_d = p_last_q;
    end

    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (advance && p_last_q) begin
      out_valid_d = 1'b1;
    end
  end

  // Control registers; first-beat flag starts set so the first beat clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    pow2_mac_lane #(
      .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
      .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH),
      .ACC_BIT_WIDTH   (ACC_BIT_WIDTH),
      .NEG_ZERO_IS_ZERO(NEG_ZERO_IS_ZERO)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .act_i    (in_data[lane_lsb(i, INPUT_BIT_WIDTH) +: INPUT_BIT_WIDTH]),
      .weight_i (in_weight[lane_lsb(i, WEIGHT_BIT_WIDTH) +: WEIGHT_BIT_WIDTH]),
      .load_i   (accept),
      .advance_i(advance),
      .first_i  (first_q),
      .emit_i   (p_last_q),
      .out_o    (out_data[lane_lsb(i, ACC_BIT_WIDTH) +: ACC_BIT_WIDTH])
    );
  end

endmodule

// File: tb/tb_pow2_mac_array.sv
// Directed bench for pow2_mac_array: three instances (default, 12-bit
// accumulator, negative-zero-as-zero) share one stimulus stream.
// Expected values are hand-computed constants.
module tb_pow2_mac_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [15:0] in_data;
  logic [15:0] in_weight;

  logic        in_ready0, in_ready_s, in_ready_n;
  logic        out_valid0, out_valid_s, out_valid_n;
  logic [95:0] out_data0;
  logic [47:0] out_data_s;
  logic [95:0] out_data_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pow2_mac_array dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  pow2_mac_array #(.ACC_BIT_WIDTH(12)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
  );

  pow2_mac_array #(.NEG_ZERO_IS_ZERO(1'b1)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n)
  );

  function automatic int lane0(input int i);
    return int'($signed(out_data0[i*24 +: 24]));
  endfunction

  function automatic int lane_s(input int i);
    return int'($signed(out_data_s[i*12 +: 12]));
  endfunction

  function automatic int lane_n(input int i);
    return int'($signed(out_data_n[i*24 +: 24]));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [15:0] w, input logic last);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    in_last   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid0); end
    checks++; if (out_data0 !== 96'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready0); end
    checks++; if (out_data_s !== 48'd0) begin errors++; $display("FAIL reset_out_data_sat: got %h want 0", out_data_s); end
  endtask

  // lane0 5*2^3 = 40, lane1 -(3*2^2) = -12, one beat.
  task automatic test_single_lane();
    drive(16'h0035, 16'h00A3, 1'b1);
    step();
    idle();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", out_valid0); end
    step();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(0) !== 40) begin errors++; $display("FAIL single_lane0: got %0d want 40", lane0(0)); end
    checks++; if (lane0(1) !== -12) begin errors++; $display("FAIL neg_weight_lane1: got %0d want -12", lane0(1)); end
    checks++; if (lane0(2) !== 0) begin errors++; $display("FAIL single_lane2_idle: got %0d want 0", lane0(2)); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %0b want 0", out_valid0); end
  endtask

  // lane2: 14 - 16 + 1 = -1, then a fresh single-beat sequence giving 4.
  task automatic test_three_beat();
    drive(16'h0700, 16'h0100, 1'b0); step();
    drive(16'h0200, 16'h0B00, 1'b0); step();
    drive(16'h0100, 16'h0000, 1'b1); step();
    drive(16'h0400, 16'h0000, 1'b1); step();
    idle();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL seq3_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(2) !== -1) begin errors++; $display("FAIL seq3_sum: got %0d want -1", lane0(2)); end
    step();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL seq_b2b_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(2) !== 4) begin errors++; $display("FAIL seq_b2b_sum: got %0d want 4", lane0(2)); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL seq_b2b_drop: got %0b want 0", out_valid0); end
  endtask

  // 12-bit accumulator on lane0: clamp high, clamp low, recover from the rail.
  task automatic test_saturation();
    drive(16'h000F, 16'h0007, 1'b0); step();
    drive(16'h000F, 16'h0007, 1'b1); step();
    idle(); step();
    checks++; if (lane_s(0) !== 2047) begin errors++; $display("FAIL sat_high: got %0d want 2047", lane_s(0)); end
    checks++; if (lane0(0) !== 3840) begin errors++; $display("FAIL wide_no_sat: got %0d want 3840", lane0(0)); end
    drive(16'h000F, 16'h000F, 1'b0); step();
    drive(16'h000F, 16'h000F, 1'b1); step();
    idle(); step();
    checks++; if (lane_s(0) !== -2048) begin errors++; $display("FAIL sat_low: got %0d want -2048", lane_s(0)); end
    checks++; if (lane0(0) !== -3840) begin errors++; $display("FAIL wide_no_sat_neg: got %0d want -3840", lane0(0)); end
    drive(16'h000F, 16'h0007, 1'b0); step();
    drive(16'h000F, 16'h0007, 1'b0); step();
    drive(16'h000F, 16'h000F, 1'b1); step();
    idle(); step();
    checks++; if (lane_s(0) !== 127) begin errors++; $display("FAIL sat_recover: got %0d want 127", lane_s(0)); end
    checks++; if (out_valid_s !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b want 1", out_valid_s); end
  endtask

  // lane3 in=9 w=1000; lane2 in=9 w=1001 (ordinary negative shift).
  task automatic test_neg_zero();
    drive(16'h9900, 16'h8900, 1'b1); step();
    idle(); step();
    checks++; if (lane_n(3) !== 0) begin errors++; $display("FAIL negzero_on: got %0d want 0", lane_n(3)); end
    checks++; if (lane0(3) !== -9) begin errors++; $display("FAIL negzero_off: got %0d want -9", lane0(3)); end
    checks++; if (lane_n(2) !== -18) begin errors++; $display("FAIL negzero_on_shift1: got %0d want -18", lane_n(2)); end
    step();
  endtask

  // Single-beat sequences 1,2,3 on lane0 with the output held back.
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(16'h0001, 16'h0000, 1'b1); step();
    drive(16'h0002, 16'h0000, 1'b1); step();
    drive(16'h0003, 16'h0000, 1'b1); step();
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready0); end
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(0) !== 1) begin errors++; $display("FAIL bp_first: got %0d want 1", lane0(0)); end
    repeat (3) step();
    checks++; if (lane0(0) !== 1) begin errors++; $display("FAIL bp_hold: got %0d want 1", lane0(0)); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %0b want 0", in_ready0); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", in_ready0); end
    step();
    idle();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(0) !== 2) begin errors++; $display("FAIL bp_second: got %0d want 2", lane0(0)); end
    step();
    checks++; if (lane0(0) !== 3) begin errors++; $display("FAIL bp_third: got %0d want 3", lane0(0)); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", out_valid0); end
  endtask

  task automatic test_reset_mid();
    drive(16'h0006, 16'h0000, 1'b1); step();
    idle(); step();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %0b want 1", out_valid0); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", out_valid0); end
    checks++; if (out_data0 !== 96'd0) begin errors++; $display("FAIL rstmid_data: got %h want 0", out_data0); end
    step();
    rst = 1'b0;
    // Accumulate a partial 10 on lane0, then reset before the sequence closes.
    drive(16'h0005, 16'h0001, 1'b0); step();
    idle(); step(); step();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    drive(16'h0001, 16'h0000, 1'b1); step();
    idle(); step();
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %0b want 1", out_valid0); end
    checks++; if (lane0(0) !== 1) begin errors++; $display("FAIL rstmid_new_sum: got %0d want 1", lane0(0)); end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_lane();
    test_three_beat();
    test_saturation();
    test_neg_zero();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
